ps2_kbd_sequencer: RTL and testbench

PS2_KBD_SEQUENCER -- requirements
Module: ps2_kbd_sequencer

---
 rtl/ps2_defs.sv | 47 ++++
 rtl/ms_timer.sv | 52 +++++
 rtl/ps2_kbd_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_ps2_kbd_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_defs.sv
// ps2_defs: shared definitions for the PS/2 keyboard command sequencer.
//   - CPU-visible status codes and keyboard host reply codes
//   - PS/2 command bytes used by the sequencer itself
//   - sequencer state encoding, job source tag and latched job record
package ps2_defs;

    // cpu_stat_o values (00/01/FA/FE are shared with the host reply status)
    localparam logic [7:0] STAT_IDLE    = 8'h00;
    localparam logic [7:0] STAT_PENDING = 8'h01;
    localparam logic [7:0] STAT_ACK     = 8'hFA;
    localparam logic [7:0] STAT_NACK    = 8'hFE;
    localparam logic [7:0] STAT_TIMEOUT = 8'hFD;

    // PS/2 keyboard commands
    localparam logic [7:0] CMD_SET_LEDS    = 8'hED;
    localparam logic [7:0] CMD_ENABLE_SCAN = 8'hF4;

    // ck1us pulses per millisecond tick, minus one (prescaler wrap value)
    localparam logic [9:0] PRESCALE_LAST = 10'd999;

    typedef enum logic [2:0] {
        ST_INIT_WAIT  = 3'd0,
        ST_IDLE       = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_ISSUE_DATA = 3'd3,
        ST_WAIT_REPLY = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SRC_INIT = 2'd0,
        SRC_CPU  = 2'd1,
        SRC_LED  = 2'd2
    } src_t;

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] data;
        logic       two_byte;
        src_t       src;
    } job_t;

    // True for the two host replies that can end an attempt.
    function automatic logic is_final_reply(input logic [7:0] stat);
        return (stat == STAT_ACK) || (stat == STAT_NACK);
    endfunction

endpackage

// File: rtl/ms_timer.sv
// ms_timer: millisecond time base for the PS/2 sequencer.
//   clk6x   in   system clock, rising edge
//   resetn  in   synchronous active-low reset
//   ck1us   in   1-cycle pulse every microsecond
//   clr_i   in   zero the ms counter (prescaler keeps running)
//   tick_o  out  1-cycle pulse every 1000 ck1us pulses
//   count_o out  ms ticks since reset / last clear, saturating
module ms_timer
    import ps2_defs::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk6x,
    input  logic             resetn,
    input  logic             ck1us,
    input  logic             clr_i,
    output logic             tick_o,
    output logic [CNT_W-1:0] count_o
);

    logic [9:0]       pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = ck1us && (pre_q == PRESCALE_LAST);
        pre_d  = pre_q;
        if (ck1us) begin
            pre_d = tick_o ? 10'd0 : pre_q + 10'd1;
        end
        // The prescaler is never cleared by clr_i, so the first ms of a
        // freshly cleared interval may be short.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_o && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/ps2_kbd_sequencer.sv
// ps2_kbd_sequencer: serialises CPU commands, LED updates and the power-up
// enable-scanning command onto a PS/2 keyboard host, one job at a time,
// with reply checking, retry on NACK/timeout and a CPU status register.
//   clk6x            in   48 MHz clock, rising edge
//   resetn           in   synchronous active-low reset
//   ck1us            in   1-cycle pulse every microsecond
//   cpu_cmd_i/data_i in   CPU command / data byte
//   cpu_req1_i/2_i   in   1-cycle request for a 1-byte / 2-byte command
//   cpu_busy_o       out  sequencer not idle (CPU requests ignored)
//   cpu_stat_o       out  00 idle, 01 pending, FA ack, FE nack, FD timeout
//   led_state_i      in   {caps, num, scroll}
//   led_upd_i        in   1-cycle LED update request
//   host_wcmddata_o  out  byte for the host TX FIFO (00 when not enqueuing)
//   host_enq_cmd1_o  out  enqueue 1-byte command or data byte of a 2-byte one
//   host_enq_cmd2_o  out  enqueue command byte of a 2-byte command
//   host_stat_i      in   host reply status 00/01/FA/FE
// TIMEOUT_MS and INIT_DELAY_MS must be at least 1.
module ps2_kbd_sequencer
    import ps2_defs::*;
#(
    parameter int         TIMEOUT_MS    = 20,
    parameter int         MAX_RETRY     = 2,
    parameter int         INIT_DELAY_MS = 500,
    parameter logic [7:0] INIT_CMD      = CMD_ENABLE_SCAN
) (
    input  logic       clk6x,
    input  logic       resetn,
    input  logic       ck1us,
    input  logic [7:0] cpu_cmd_i,
    input  logic [7:0] cpu_data_i,
    input  logic       cpu_req1_i,
    input  logic       cpu_req2_i,
    output logic       cpu_busy_o,
    output logic [7:0] cpu_stat_o,
    input  logic [2:0] led_state_i,
    input  logic       led_upd_i,
    output logic [7:0] host_wcmddata_o,
    output logic       host_enq_cmd1_o,
    output logic       host_enq_cmd2_o,
    input  logic [7:0] host_stat_i
);

    localparam int               CNT_W     = 16;
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_DELAY_MS - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_MS - 1);
    localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRY);

    state_t     state_q, state_d;
    job_t       job_q, job_d;
    logic [7:0] retry_q, retry_d;
    logic       armed_q, armed_d;
    logic [7:0] cpu_stat_q, cpu_stat_d;
    logic       led_pend_q, led_pend_d;
    logic [2:0] led_val_q, led_val_d;
    logic       enq1_q, enq1_d;
    logic       enq2_q, enq2_d;
    logic [7:0] wdata_q, wdata_d;

    logic             ms_tick;
    logic             ms_clr;
    logic [CNT_W-1:0] ms_count;

    logic       att_fail;
    logic       job_done;
    logic [7:0] res_code;

    ms_timer #(
        .CNT_W (CNT_W)
    ) u_ms_timer (
        .clk6x   (clk6x),
        .resetn  (resetn),
        .ck1us   (ck1us),
        .clr_i   (ms_clr),
        .tick_o  (ms_tick),
        .count_o (ms_count)
    );

    always_comb begin
        state_d    = state_q;
        job_d      = job_q;
        retry_d    = retry_q;
        armed_d    = armed_q;
        cpu_stat_d = cpu_stat_q;
        // LED requests are captured in every state; later pulses overwrite.
        led_pend_d = led_pend_q | led_upd_i;
        led_val_d  = led_upd_i ? led_state_i : led_val_q;
        enq1_d     = 1'b0;
        enq2_d     = 1'b0;
        wdata_d    = 8'h00;
        ms_clr     = 1'b0;
        att_fail   = 1'b0;
        job_done   = 1'b0;
        res_code   = STAT_TIMEOUT;

        unique case (state_q)
            ST_INIT_WAIT: begin
                // ms counter has run since reset; fire on the last delay tick
                if (ms_tick && (ms_count == INIT_LAST)) begin
                    job_d   = '{cmd: INIT_CMD, data: 8'h00, two_byte: 1'b0, src: SRC_INIT};
                    retry_d = 8'd0;
                    state_d = ST_ISSUE;
                end
            end

            ST_IDLE: begin
                if (cpu_req2_i) begin
                    job_d      = '{cmd: cpu_cmd_i, data: cpu_data_i, two_byte: 1'b1, src: SRC_CPU};
                    retry_d    = 8'd0;
                    cpu_stat_d = STAT_PENDING;
                    state_d    = ST_ISSUE;
                end else if (cpu_req1_i) begin
                    job_d      = '{cmd: cpu_cmd_i, data: 8'h00, two_byte: 1'b0, src: SRC_CPU};
                    retry_d    = 8'd0;
                    cpu_stat_d = STAT_PENDING;
                    state_d    = ST_ISSUE;
                end else if (led_pend_q) begin
                    job_d      = '{cmd: CMD_SET_LEDS, data: {5'b0, led_val_q},
                                   two_byte: 1'b1, src: SRC_LED};
                    retry_d    = 8'd0;
                    // a pulse in this very cycle becomes the next LED job
                    led_pend_d = led_upd_i;
                    state_d    = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                wdata_d = job_q.cmd;
                if (job_q.two_byte) begin
                    enq2_d  = 1'b1;
                    state_d = ST_ISSUE_DATA;
                end else begin
                    enq1_d  = 1'b1;
                    ms_clr  = 1'b1;
                    armed_d = 1'b0;
                    state_d = ST_WAIT_REPLY;
                end
            end

            ST_ISSUE_DATA: begin
                enq1_d  = 1'b1;
                wdata_d = job_q.data;
                ms_clr  = 1'b1;
                armed_d = 1'b0;
                state_d = ST_WAIT_REPLY;
            end

            ST_WAIT_REPLY: begin
                // host_stat_i may still show the previous job's FA/FE; only a
                // reply seen after 01 (host accepted our bytes) counts.
                if (host_stat_i == STAT_PENDING) begin
                    armed_d = 1'b1;
                end
                if (armed_q && is_final_reply(host_stat_i)) begin
                    res_code = host_stat_i;
                    if (host_stat_i == STAT_ACK) begin
                        job_done = 1'b1;
                    end else begin
                        att_fail = 1'b1;
                    end
                end else if (ms_tick && (ms_count == TMO_LAST)) begin
                    res_code = STAT_TIMEOUT;
                    att_fail = 1'b1;
                end

                if (att_fail) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 8'd1;
                        state_d = ST_ISSUE;
                    end else begin
                        job_done = 1'b1;
                    end
                end

                if (job_done) begin
                    state_d = ST_IDLE;
                    if (job_q.src == SRC_CPU) begin
                        cpu_stat_d = res_code;
                    end
                end
            end

            default: begin
                state_d = ST_INIT_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            state_q    <= ST_INIT_WAIT;
            job_q      <= '0;
            retry_q    <= 8'd0;
            armed_q    <= 1'b0;
            cpu_stat_q <= STAT_IDLE;
            led_pend_q <= 1'b0;
            led_val_q  <= 3'b000;
            enq1_q     <= 1'b0;
            enq2_q     <= 1'b0;
            wdata_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            job_q      <= job_d;
            retry_q    <= retry_d;
            armed_q    <= armed_d;
            cpu_stat_q <= cpu_stat_d;
            led_pend_q <= led_pend_d;
            led_val_q  <= led_val_d;
            enq1_q     <= enq1_d;
            enq2_q     <= enq2_d;
            wdata_q    <= wdata_d;
        end
    end

    assign cpu_busy_o      = (state_q != ST_IDLE);
    assign cpu_stat_o      = cpu_stat_q;
    assign host_enq_cmd1_o = enq1_q;
    assign host_enq_cmd2_o = enq2_q;
    assign host_wcmddata_o = wdata_q;

endmodule

// File: tb/tb_ps2_kbd_sequencer.sv
// Bench for ps2_kbd_sequencer: a scripted keyboard-host model answers each
// attempt (stale status, then 01, then FA/FE or silence); expected attempts,
// byte sequence and final status come from a per-job reply script.
module tb_ps2_kbd_sequencer;

    localparam int TMO    = 2;
    localparam int MAXR   = 2;
    localparam int INITD  = 2;
    localparam int MS_CYC = 2000;  // ck1us every 2nd cycle -> 2000 cycles/ms

    logic       clk6x = 1'b0;
    logic       resetn = 1'b0;
    logic       ck1us = 1'b0;
    logic [7:0] cpu_cmd_i = 8'h00;
    logic [7:0] cpu_data_i = 8'h00;
    logic       cpu_req1_i = 1'b0;
    logic       cpu_req2_i = 1'b0;
    logic       cpu_busy_o;
    logic [7:0] cpu_stat_o;
    logic [2:0] led_state_i = 3'b000;
    logic       led_upd_i = 1'b0;
    logic [7:0] host_wcmddata_o;
    logic       host_enq_cmd1_o;
    logic       host_enq_cmd2_o;
    logic [7:0] host_stat_i = 8'h00;

    ps2_kbd_sequencer #(
        .TIMEOUT_MS    (TMO),
        .MAX_RETRY     (MAXR),
        .INIT_DELAY_MS (INITD),
        .INIT_CMD      (8'hF4)
    ) dut (
        .clk6x           (clk6x),
        .resetn          (resetn),
        .ck1us           (ck1us),
        .cpu_cmd_i       (cpu_cmd_i),
        .cpu_data_i      (cpu_data_i),
        .cpu_req1_i      (cpu_req1_i),
        .cpu_req2_i      (cpu_req2_i),
        .cpu_busy_o      (cpu_busy_o),
        .cpu_stat_o      (cpu_stat_o),
        .led_state_i     (led_state_i),
        .led_upd_i       (led_upd_i),
        .host_wcmddata_o (host_wcmddata_o),
        .host_enq_cmd1_o (host_enq_cmd1_o),
        .host_enq_cmd2_o (host_enq_cmd2_o),
        .host_stat_i     (host_stat_i)
    );

    always #10 clk6x = ~clk6x;

    initial begin
        forever begin
            @(posedge clk6x);
            #1;
            ck1us = ~ck1us;
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_pulse = 0;
    int wd_err = 0;
    int first_pulse_cyc = 0;
    logic [7:0] scr[$];  // reply per attempt: FA, FE, or 00 = silence

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic pulsing();
        return host_enq_cmd1_o || host_enq_cmd2_o;
    endfunction

    // One clock; outputs are observed 2 time units after the edge.
    task automatic tick();
        @(posedge clk6x);
        #2;
        cyc++;
        if (pulsing()) n_pulse++;
        else if (host_wcmddata_o != 8'h00) wd_err++;
        if (host_enq_cmd1_o && host_enq_cmd2_o) wd_err++;
    endtask

    // Expected outcome of a job from its reply script.
    function automatic void model(output int att, output logic [7:0] fin);
        logic [7:0] r;
        att = MAXR + 1;
        fin = 8'hFD;
        for (int a = 0; a <= MAXR; a++) begin
            r = (a < scr.size()) ? scr[a] : 8'h00;
            if (r == 8'hFA) begin
                att = a + 1;
                fin = 8'hFA;
                return;
            end
            fin = (r == 8'hFE) ? 8'hFE : 8'hFD;
        end
    endfunction

    // Acts as keyboard host for one job; checks the enqueued bytes per attempt.
    task automatic serve(input logic [7:0] cmd, input logic [7:0] data, input bit two,
                         input bit inj, input int bound0, output logic [7:0] fin);
        int att;
        int p0;
        int n;
        int bound;
        model(att, fin);
        p0 = n_pulse - (pulsing() ? 1 : 0);
        bound = TMO * MS_CYC + 200;
        for (int a = 0; a < att; a++) begin
            n = 0;
            while (!pulsing() && n < bound0) begin
                tick();
                n++;
            end
            if (!pulsing()) begin
                chk("pulse_wait_expired", 32'(n), 32'(0));
                return;
            end
            if (a == 0) first_pulse_cyc = cyc;
            if (two) begin
                chk("cmd2_kind", 32'({host_enq_cmd2_o, host_enq_cmd1_o}), 32'(2'b10));
                chk("cmd2_byte", 32'(host_wcmddata_o), 32'(cmd));
                tick();
                chk("data_kind", 32'({host_enq_cmd2_o, host_enq_cmd1_o}), 32'(2'b01));
                chk("data_byte", 32'(host_wcmddata_o), 32'(data));
            end else begin
                chk("cmd1_kind", 32'({host_enq_cmd2_o, host_enq_cmd1_o}), 32'(2'b01));
                chk("cmd1_byte", 32'(host_wcmddata_o), 32'(cmd));
            end
            if (inj && a == 0) begin
                // two LED updates (coalesce to the second) and an ignored CPU request
                led_state_i = 3'b001; led_upd_i = 1'b1;
                tick();
                led_upd_i = 1'b0; led_state_i = 3'b110;
                tick();
                led_state_i = 3'b101; led_upd_i = 1'b1;
                cpu_cmd_i = 8'h55; cpu_req1_i = 1'b1;
                tick();
                led_upd_i = 1'b0; cpu_req1_i = 1'b0; led_state_i = 3'b010;
            end
            // host_stat_i still holds the previous reply here
            repeat ($urandom_range(2, 5)) tick();
            chk("stale_ignored", 32'(cpu_busy_o), 32'(1));
            host_stat_i = 8'h01;
            repeat ($urandom_range(1, 3)) tick();
            if (a < scr.size() && scr[a] != 8'h00) host_stat_i = scr[a];
            n = 0;
            while (cpu_busy_o && !pulsing() && n < bound) begin
                tick();
                n++;
            end
            if (cpu_busy_o && !pulsing()) begin
                chk("reply_wait_expired", 32'(n), 32'(0));
                return;
            end
        end
        chk("job_idle", 32'(cpu_busy_o), 32'(0));
        chk("pulse_count", 32'(n_pulse - p0), 32'(att * (two ? 2 : 1)));
    endtask

    task automatic cpu_req(input logic [7:0] c, input logic [7:0] d, input int sel);
        cpu_cmd_i  = c;
        cpu_data_i = d;
        cpu_req1_i = (sel != 1);
        cpu_req2_i = (sel != 0);
        tick();
        cpu_req1_i = 1'b0;
        cpu_req2_i = 1'b0;
    endtask

    initial begin
        logic [7:0] fin;
        int t0;
        int p;
        int n;

        // reset state
        resetn = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(cpu_busy_o), 32'(1));
        chk("rst_stat", 32'(cpu_stat_o), 32'h00);
        chk("rst_enq", 32'({host_enq_cmd2_o, host_enq_cmd1_o}), 32'(0));
        chk("rst_wdata", 32'(host_wcmddata_o), 32'h00);

        // power-up init command after INITD ms
        resetn = 1'b1;
        t0 = cyc;
        scr = {};
        scr.push_back(8'hFA);
        serve(8'hF4, 8'h00, 1'b0, 1'b0, 6000, fin);
        chk("init_delay_lo", 32'((first_pulse_cyc - t0) >= INITD * MS_CYC - 100), 32'(1));
        chk("init_delay_hi", 32'((first_pulse_cyc - t0) <= INITD * MS_CYC + 100), 32'(1));
        chk("init_stat", 32'(cpu_stat_o), 32'h00);

        // CPU 2-byte F3 20, host still showing stale FA from init
        cpu_req(8'hF3, 8'h20, 1);
        chk("f3_pend", 32'(cpu_stat_o), 32'h01);
        scr = {};
        scr.push_back(8'hFA);
        serve(8'hF3, 8'h20, 1'b1, 1'b0, 100, fin);
        chk("f3_stat", 32'(cpu_stat_o), 32'(fin));

        // NACK twice then ack
        cpu_req(8'hFF, 8'h00, 0);
        scr = {};
        scr.push_back(8'hFE); scr.push_back(8'hFE); scr.push_back(8'hFA);
        serve(8'hFF, 8'h00, 1'b0, 1'b0, 100, fin);
        chk("nack_retry_stat", 32'(cpu_stat_o), 32'hFA);

        // NACK on every attempt
        cpu_req(8'hF0, 8'h02, 2);
        scr = {};
        scr.push_back(8'hFE); scr.push_back(8'hFE); scr.push_back(8'hFE);
        serve(8'hF0, 8'h02, 1'b1, 1'b0, 100, fin);
        chk("nack_final_stat", 32'(cpu_stat_o), 32'hFE);

        // silent keyboard: three timed-out attempts
        t0 = cyc;
        cpu_req(8'hEE, 8'h00, 0);
        scr = {};
        serve(8'hEE, 8'h00, 1'b0, 1'b0, 100, fin);
        chk("tmo_stat", 32'(cpu_stat_o), 32'hFD);
        chk("tmo_dur_lo", 32'((cyc - t0) >= 3 * (TMO - 1) * MS_CYC), 32'(1));
        chk("tmo_dur_hi", 32'((cyc - t0) <= 3 * TMO * MS_CYC + 100), 32'(1));

        // LED updates during a busy CPU job coalesce into one ED,05 job
        cpu_req(8'hF2, 8'h00, 0);
        scr = {};
        scr.push_back(8'hFA);
        serve(8'hF2, 8'h00, 1'b0, 1'b1, 100, fin);
        chk("arb_cpu_stat", 32'(cpu_stat_o), 32'hFA);
        scr = {};
        scr.push_back(8'hFA);
        serve(8'hED, 8'h05, 1'b1, 1'b0, 10, fin);
        chk("arb_led_stat", 32'(cpu_stat_o), 32'hFA);
        p = n_pulse;
        repeat (50) tick();
        chk("arb_no_extra_job", 32'(n_pulse - p), 32'(0));

        // failing LED job leaves cpu_stat_o alone
        led_state_i = 3'b010; led_upd_i = 1'b1;
        tick();
        led_upd_i = 1'b0;
        scr = {};
        scr.push_back(8'hFE); scr.push_back(8'hFE); scr.push_back(8'hFE);
        serve(8'hED, 8'h02, 1'b1, 1'b0, 10, fin);
        chk("led_fail_stat", 32'(cpu_stat_o), 32'hFA);

        // randomized CPU jobs
        for (int j = 0; j < 10; j++) begin
            logic [7:0] c;
            logic [7:0] d;
            int sel;
            int k;
            c = 8'($urandom);
            d = 8'($urandom);
            sel = $urandom_range(0, 2);
            k = $urandom_range(0, 3);
            scr = {};
            for (int i = 0; i < k; i++) scr.push_back(8'hFE);
            scr.push_back(8'hFA);
            cpu_req(c, d, sel);
            chk("rnd_pend", 32'(cpu_stat_o), 32'h01);
            serve(c, d, sel != 0, 1'b0, 100, fin);
            chk("rnd_stat", 32'(cpu_stat_o), 32'(fin));
        end

        // reset in the middle of a job, with an LED update pending
        cpu_req(8'hF5, 8'h00, 0);
        n = 0;
        while (!pulsing() && n < 100) begin
            tick();
            n++;
        end
        chk("rst_job_started", 32'(pulsing()), 32'(1));
        led_state_i = 3'b011; led_upd_i = 1'b1;
        tick();
        led_upd_i = 1'b0;
        resetn = 1'b0;
        tick();
        chk("rst2_busy", 32'(cpu_busy_o), 32'(1));
        chk("rst2_stat", 32'(cpu_stat_o), 32'h00);
        chk("rst2_enq", 32'({host_enq_cmd2_o, host_enq_cmd1_o}), 32'(0));
        resetn = 1'b1;
        p = n_pulse;
        repeat (200) tick();
        chk("rst2_abandoned", 32'(n_pulse - p), 32'(0));
        scr = {};
        scr.push_back(8'hFA);
        serve(8'hF4, 8'h00, 1'b0, 1'b0, 6000, fin);
        chk("rst2_init_stat", 32'(cpu_stat_o), 32'h00);
        p = n_pulse;
        repeat (60) tick();
        chk("rst2_led_dropped", 32'(n_pulse - p), 32'(0));

        chk("wdata_zero_when_idle", 32'(wd_err), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
